pipe_ctrl: RTL and testbench

Pipeline control unit for the dual-issue core. It generates the `stop` (hold) and flush (bubble-insert) controls for four places: the fetch unit, the instruction buffer, the two DE→EX pipeline registers and the two EX→WB pipeline registers. It decides these from the load-use hazard, the branch redirect and the data-memory handshake. It sits beside the datapath and contains only control state (FSM and counters); it holds no instruction or operand data.

---
 rtl/pipe_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hazard, redirect and memory-wait stop/flush control for the dual-issue pipeline
//
// Purpose:
//   Generates the hold (stop_*) and bubble (flush_*) controls for fetch, the
//   instruction buffer, the DE->EX and EX->WB pipeline registers.
//   Inputs are the load-use hazard, the branch redirect and the data-memory
//   handshake. Holds only control state: a 4-state FSM and one 8-bit counter.
//   Controls are combinational with 0-cycle latency.
//
// Parameters:
//   LU_CYCLES   (1..15)  bubbles per load-use hazard
//   FLUSH_LEN   (1..15)  extra squash cycles after a redirect
//   MEM_TIMEOUT (2..255) wait cycles before a memory access is abandoned
//
// Configuration macro:
//   PIPE_CTRL_PERF_EN    builds the stall_cycles / flush_count counters;
//                        when undefined both ports are tied to 0
//
// Ports:
//   clk, reset (async, active high)
//   lu_hazard, br_taken, mem_req, mem_ack            hazard / handshake inputs
//   stop_if, stop_buf, stop_deex                     hold controls
//   flush_buf, flush_deex, flush_exwb, redirect      bubble / redirect controls
//   mem_err                                          one-cycle timeout pulse
//   stall_cycles, flush_count                        32-bit perf counters

module pipe_ctrl #(
    parameter int unsigned LU_CYCLES   = 1,
    parameter int unsigned FLUSH_LEN   = 1,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lu_hazard,
    input  logic        br_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        stop_if,
    output logic        stop_buf,
    output logic        stop_deex,
    output logic        flush_buf,
    output logic        flush_deex,
    output logic        flush_exwb,
    output logic        redirect,
    output logic        mem_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [7:0] LP_FLUSH_LEN = 8'(FLUSH_LEN);
    localparam logic [7:0] LP_LU_INIT   = 8'(LU_CYCLES - 1);
    localparam logic [7:0] LP_TIMEOUT   = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    logic w_memstall;
    logic w_run_eval;
    logic w_stop_if;
    logic w_stop_buf;
    logic w_stop_deex;
    logic w_flush_buf;
    logic w_flush_deex;
    logic w_flush_exwb;
    logic w_redirect;
    logic w_mem_err;

    assign w_memstall = mem_req & ~mem_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_run_eval   = 1'b0;
        w_stop_if    = 1'b0;
        w_stop_buf   = 1'b0;
        w_stop_deex  = 1'b0;
        w_flush_buf  = 1'b0;
        w_flush_deex = 1'b0;
        w_flush_exwb = 1'b0;
        w_redirect   = 1'b0;
        w_mem_err    = 1'b0;

        case (r_state)
            RUN: begin
                w_run_eval = 1'b1;
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    // Release cycle: EX re-presents the held instructions, so
                    // their branch/hazard outcome is acted on right now.
                    w_run_eval = 1'b1;
                end else if (r_cnt == LP_TIMEOUT) begin
                    // Abandon the access; all holds drop in the error cycle.
                    w_mem_err   = 1'b1;
                    w_state_nxt = RUN;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_stop_if    = 1'b1;
                    w_stop_buf   = 1'b1;
                    w_stop_deex  = 1'b1;
                    w_flush_exwb = 1'b1;
                    w_cnt_nxt    = r_cnt + 8'd1;
                end
            end
            LU_STALL: begin
                // A memory stall or a branch overrides the remaining bubbles;
                // the common evaluation below applies the right priority.
                if (w_memstall || br_taken) begin
                    w_run_eval = 1'b1;
                end else begin
                    w_stop_if    = 1'b1;
                    w_stop_buf   = 1'b1;
                    w_flush_deex = 1'b1;
                    if (r_cnt <= 8'd1) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
            end
            FLUSH: begin
                // EX holds a bubble, so a memory stall is unexpected here; it is
                // still honoured rather than dropped.
                if (w_memstall) begin
                    w_run_eval = 1'b1;
                end else begin
                    w_flush_deex = 1'b1;
                    if (r_cnt <= 8'd1) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 8'd0;
            end
        endcase

        if (w_run_eval) begin
            if (w_memstall) begin
                w_stop_if    = 1'b1;
                w_stop_buf   = 1'b1;
                w_stop_deex  = 1'b1;
                w_flush_exwb = 1'b1;
                w_state_nxt  = MEM_WAIT;
                w_cnt_nxt    = 8'd1;
            end else if (br_taken) begin
                w_flush_buf  = 1'b1;
                w_flush_deex = 1'b1;
                w_redirect   = 1'b1;
                w_state_nxt  = FLUSH;
                w_cnt_nxt    = LP_FLUSH_LEN;
            end else if (lu_hazard) begin
                w_stop_if    = 1'b1;
                w_stop_buf   = 1'b1;
                w_flush_deex = 1'b1;
                if (LU_CYCLES > 1) begin
                    w_state_nxt = LU_STALL;
                    w_cnt_nxt   = LP_LU_INIT;
                end else begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = 8'd0;
                end
            end else begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 8'd0;
            end
        end
    end

    // The pipeline registers have their own reset, so every control is
    // forced low for as long as reset is high, including mid-stall.
    assign stop_if    = w_stop_if    & ~reset;
    assign stop_buf   = w_stop_buf   & ~reset;
    assign stop_deex  = w_stop_deex  & ~reset;
    assign flush_buf  = w_flush_buf  & ~reset;
    assign flush_deex = w_flush_deex & ~reset;
    assign flush_exwb = w_flush_exwb & ~reset;
    assign redirect   = w_redirect   & ~reset;
    assign mem_err    = w_mem_err    & ~reset;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (stop_if) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (redirect) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl against a cycle-level behavioural model

module tb_pipe_ctrl;

    localparam int LU_CYC  = 2;
    localparam int FL_LEN  = 2;
    localparam int MEM_TO  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lu_hazard = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ack = 1'b0;
    logic        stop_if, stop_buf, stop_deex;
    logic        flush_buf, flush_deex, flush_exwb;
    logic        redirect, mem_err;
    logic [31:0] stall_cycles, flush_count;

    pipe_ctrl #(
        .LU_CYCLES  (LU_CYC),
        .FLUSH_LEN  (FL_LEN),
        .MEM_TIMEOUT(MEM_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lu_hazard   (lu_hazard),
        .br_taken    (br_taken),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .stop_if     (stop_if),
        .stop_buf    (stop_buf),
        .stop_deex   (stop_deex),
        .flush_buf   (flush_buf),
        .flush_deex  (flush_deex),
        .flush_exwb  (flush_exwb),
        .redirect    (redirect),
        .mem_err     (mem_err),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
    );

    always #5 clk = ~clk;

    // ctl = {stop_if, stop_buf, stop_deex, flush_buf, flush_deex, flush_exwb, redirect, mem_err}
    typedef struct packed {
        logic [7:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model: outstanding work is tracked as "bubbles still owed"
    // and "cycles already waited", not as controller states.
    bit          m_mem_active = 0;
    int          m_waited     = 0;
    int          m_lu_left    = 0;
    int          m_fl_left    = 0;
    logic [31:0] m_stall      = 0;
    logic [31:0] m_flush      = 0;

    localparam logic [7:0] C_MEM = 8'b1110_0100;
    localparam logic [7:0] C_BR  = 8'b0001_1010;
    localparam logic [7:0] C_LU  = 8'b1100_1000;
    localparam logic [7:0] C_FL  = 8'b0000_1000;
    localparam logic [7:0] C_ERR = 8'b0000_0001;

    function automatic exp_t model(bit rst, bit lu, bit br, bit req, bit ack);
        exp_t e;
        bit   ms;
        e     = '0;
        e.cyc = cyc;
        ms    = req & ~ack;
        if (rst) begin
            m_mem_active = 0;
            m_waited     = 0;
            m_lu_left    = 0;
            m_fl_left    = 0;
            m_stall      = 0;
            m_flush      = 0;
            return e;
        end
        e.sc = m_stall;
        e.fc = m_flush;
        if (m_mem_active && !ack) begin
            if (m_waited == MEM_TO) begin
                e.ctl        = C_ERR;
                m_mem_active = 0;
            end else begin
                e.ctl    = C_MEM;
                m_waited = m_waited + 1;
            end
        end else begin
            m_mem_active = 0;
            if (ms) begin
                e.ctl        = C_MEM;
                m_mem_active = 1;
                m_waited     = 1;
                m_lu_left    = 0;
                m_fl_left    = 0;
            end else if (m_fl_left > 0) begin
                e.ctl     = C_FL;
                m_fl_left = m_fl_left - 1;
            end else if (br) begin
                e.ctl     = C_BR;
                m_fl_left = FL_LEN;
                m_lu_left = 0;
            end else if (m_lu_left > 0) begin
                e.ctl     = C_LU;
                m_lu_left = m_lu_left - 1;
            end else if (lu) begin
                e.ctl     = C_LU;
                m_lu_left = LU_CYC - 1;
            end
        end
`ifdef PIPE_CTRL_PERF_EN
        if (e.ctl[7]) m_stall = m_stall + 32'd1;
        if (e.ctl[1]) m_flush = m_flush + 32'd1;
`endif
        return e;
    endfunction

    task automatic step(input bit rst, input bit lu, input bit br, input bit req, input bit ack);
        @(posedge clk);
        #1;
        cyc       = cyc + 1;
        reset     = rst;
        lu_hazard = lu;
        br_taken  = br;
        mem_req   = req;
        mem_ack   = ack;
        sb.push_back(model(rst, lu, br, req, ack));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_t        e;
        logic [7:0]  act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {stop_if, stop_buf, stop_deex, flush_buf, flush_deex,
                       flush_exwb, redirect, mem_err};
                checks = checks + 1;
                if (act !== e.ctl) begin
                    errors = errors + 1;
                    $display("FAIL ctl cycle=%0d actual=%b required=%b", e.cyc, act, e.ctl);
                end
                checks = checks + 1;
                if (stall_cycles !== e.sc || flush_count !== e.fc) begin
                    errors = errors + 1;
                    $display("FAIL perf cycle=%0d actual=%0d/%0d required=%0d/%0d",
                             e.cyc, stall_cycles, flush_count, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        int ack_pct;
        bit lu, br, req, ack, rst;

        // Reset and idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(3);
        // Load-use pulse
        step(0, 1, 0, 0, 0);
        idle(3);
        // Branch
        step(0, 0, 1, 0, 0);
        idle(4);
        // Memory wait, ack on the fourth cycle
        repeat (3) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        idle(2);
        // Memory wait with branch held; redirect only in the release cycle
        repeat (3) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        idle(4);
        // Timeout
        repeat (5) step(0, 0, 0, 1, 0);
        idle(3);
        // Load-use interrupted by a branch, then by a memory stall
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(4);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        idle(3);
        // Reset mid-stall
        repeat (2) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        idle(3);

        // Randomized traffic
        for (int blk = 0; blk < 12; blk++) begin
            ack_pct = (blk % 3 == 0) ? 0 : 35;
            for (int i = 0; i < 60; i++) begin
                rst = ($urandom_range(0, 199) == 0);
                lu  = ($urandom_range(0, 99) < 25);
                br  = ($urandom_range(0, 99) < 15);
                if (m_mem_active) begin
                    req = 1;
                    ack = ($urandom_range(0, 99) < ack_pct);
                end else begin
                    req = ($urandom_range(0, 99) < 20);
                    ack = req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
                end
                step(rst, lu, br, req, ack);
            end
        end
        idle(2);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
